imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: byte-address width of the instruction memory (4096 bytes).
REQ-002 Parameter DATA_WIDTH, default 8: byte width of the memory write port and the input stream.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  level sampled each cycle; begins a load (IDLE or RUN only).
REQ-006 len  input  ADDR_WIDTH+1  byte count for the load, sampled on the accepted start.
REQ-007 abort  input  1  cancels a load in progress.
REQ-008 in_valid  input  1  stream byte present.
REQ-009 in_data  input  DATA_WIDTH  stream byte.
REQ-010 in_ready  output  1  loader accepts a byte this cycle.
REQ-011 mem_we  output  1  byte write enable to the instruction memory.
REQ-012 mem_addr  output  ADDR_WIDTH  byte write address.
REQ-013 mem_wd  output  DATA_WIDTH  byte write data.
REQ-014 cpu_stall  output  1  holds the CPU (PC and register writes) while the memory is not ready.
REQ-015 done  output  1  one-cycle pulse on successful load completion.
REQ-016 byte_cnt  output  ADDR_WIDTH+1  bytes written in the current or last load.
REQ-017 checksum  output  DATA_WIDTH  modulo-2^DATA_WIDTH sum of the bytes written in the current or last load.

Function
REQ-018 States: IDLE, LOAD, RUN; encoded as an enum.
REQ-019 IDLE: in_ready=0, mem_we=0, cpu_stall=1.
REQ-020 IDLE or RUN, start=1: latch len, clear byte_cnt and checksum, next state LOAD; if len=0, next state RUN and pulse done instead.
REQ-021 len values above 2^ADDR_WIDTH saturate to 2^ADDR_WIDTH.
REQ-022 LOAD: in_ready=1, cpu_stall=1.
REQ-023 LOAD: mem_we is combinational = in_valid & in_ready & ~abort.
REQ-024 LOAD: mem_addr = byte_cnt[ADDR_WIDTH-1:0] and mem_wd = in_data in the same cycle, giving zero-latency writes.
REQ-025 Each accepted byte increments byte_cnt by 1 and adds in_data to checksum, truncated to DATA_WIDTH, at the next edge.
REQ-026 Acceptance of byte number len-1 moves to RUN at the next edge and asserts done for exactly that first RUN cycle.
REQ-027 in_valid=0 in LOAD: no write, no counter change; the state holds indefinitely.
REQ-028 abort=1 in LOAD has priority over a byte: no write, next state IDLE, byte_cnt and checksum hold their partial values, done stays 0.
REQ-029 abort outside LOAD is ignored.
REQ-030 start during LOAD is ignored.
REQ-031 RUN: in_ready=0, mem_we=0, cpu_stall=0.
REQ-032 RUN, start=1: reload; cpu_stall rises in the same cycle that the state enters LOAD.
REQ-033 mem_addr never wraps, because the saturation in REQ-021 bounds the address at 2^ADDR_WIDTH-1.
REQ-034 When mem_we=0, mem_addr and mem_wd are don't-care; drive them as in REQ-024 regardless.

Reset
REQ-035 rst=1 at an edge: state=IDLE, byte_cnt=0, checksum=0, done=0, latched len=0.
REQ-036 The outputs then follow REQ-019.
REQ-037 rst has priority over start and abort.
REQ-038 rst mid-LOAD discards the load with no done pulse.

Structure
REQ-039 A shared package holds the state enum type, ADDR_WIDTH, DATA_WIDTH, and the derived constant MAX_LEN = 2^ADDR_WIDTH.
REQ-040 Single module with no sub-modules.
REQ-041 The write port targets a byte-writable variant of the instruction memory; the top level muxes that memory's read address to the PC.

Verification
REQ-042 start, len=4, bytes 0x13,0x00,0x00,0x00 streamed back-to-back -> writes at addresses 0..3 on consecutive cycles, done pulses the cycle after the 4th byte, checksum=0x13, byte_cnt=4, cpu_stall=0.
REQ-043 len=3, in_valid toggling 1,0,1,0,1 -> exactly 3 writes at addresses 0,1,2 with no write on the idle cycles; done after the last byte.
REQ-044 len=8, abort raised alongside byte 3 -> no write for that byte, state IDLE, byte_cnt=3, cpu_stall=1, no done pulse.
REQ-045 len=0 -> done pulse, RUN, no writes.
REQ-046 len=5000 streaming 4096 bytes of 0xFF -> last write at address 0xFFF, byte_cnt=4096, checksum=0x00, done pulses.
REQ-047 rst asserted after 2 bytes of a 4-byte load -> IDLE, byte_cnt=0, checksum=0, in_ready=0, no done pulse; a subsequent start with the same data restarts the writes at address 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the instruction-memory byte loader.
package imem_loader_pkg;
    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_LEN    = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;
endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in, byte-wide instruction-memory write port out.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = imem_loader_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = imem_loader_pkg::DATA_WIDTH
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wd;

    // master: stream source / memory observer; slave: the loader
    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wd
    );
    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wd
    );
endinterface

// File: rtl/imem_loader.sv
// Streams len bytes into instruction memory at addresses 0..len-1 while
// stalling the CPU; releases the CPU (RUN) once the image is complete.
module imem_loader #(
    parameter int ADDR_WIDTH = imem_loader_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = imem_loader_pkg::DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH:0]   i_len,
    input  logic                  i_abort,
    imem_loader_if.slave          bus,
    output logic                  o_cpu_stall,
    output logic                  o_done,
    output logic [ADDR_WIDTH:0]   o_byte_cnt,
    output logic [DATA_WIDTH-1:0] o_checksum
);
    import imem_loader_pkg::*;

    localparam logic [ADDR_WIDTH:0] L_MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] L_ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                r_state;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_byte_cnt;
    logic [DATA_WIDTH-1:0] r_checksum;
    logic                  r_done;

    logic                  w_load;
    logic                  w_accept;
    logic                  w_last;
    logic [ADDR_WIDTH:0]   w_len_sat;

    assign w_load    = (r_state == ST_LOAD);
    assign w_accept  = bus.in_valid & w_load & ~i_abort;
    assign w_last    = (r_byte_cnt == (r_len - L_ONE));
    // Clamping to the memory size keeps the write address from wrapping.
    assign w_len_sat = (i_len > L_MAX_LEN) ? L_MAX_LEN : i_len;

    assign bus.in_ready = w_load;
    assign bus.mem_we   = w_accept;
    assign bus.mem_addr = r_byte_cnt[ADDR_WIDTH-1:0];
    assign bus.mem_wd   = bus.in_data;

    assign o_cpu_stall = (r_state != ST_RUN);
    assign o_done      = r_done;
    assign o_byte_cnt  = r_byte_cnt;
    assign o_checksum  = r_checksum;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_byte_cnt <= '0;
            r_checksum <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_RUN: begin
                    if (i_start) begin
                        r_len      <= w_len_sat;
                        r_byte_cnt <= '0;
                        r_checksum <= '0;
                        if (w_len_sat == '0) begin
                            r_state <= ST_RUN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    // Abort wins over a byte presented in the same cycle.
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                    end else if (bus.in_valid) begin
                        r_byte_cnt <= r_byte_cnt + L_ONE;
                        r_checksum <= r_checksum + bus.in_data;
                        if (w_last) begin
                            r_state <= ST_RUN;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader with a write-log reference model.
module tb_imem_loader;
    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW:0]   len;
    logic          abort;
    logic          cpu_stall;
    logic          done;
    logic [AW:0]   byte_cnt;
    logic [DW-1:0] checksum;

    imem_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

    imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_len       (len),
        .i_abort     (abort),
        .bus         (ifc.slave),
        .o_cpu_stall (cpu_stall),
        .o_done      (done),
        .o_byte_cnt  (byte_cnt),
        .o_checksum  (checksum)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int wq_addr[$];
    int wq_data[$];
    int wq_cyc[$];
    logic [DW-1:0] tx [0:4095];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Log every memory write and done pulse away from the active edge.
    always @(negedge clk) begin
        if (ifc.mem_we === 1'b1) begin
            wq_addr.push_back(int'(ifc.mem_addr));
            wq_data.push_back(int'(ifc.mem_wd));
            wq_cyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic do_start(int l);
        start = 1'b1;
        len   = l[AW:0];
        tick();
        start = 1'b0;
        len   = AW'($urandom);
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle between bytes, 2 random 0..2 idles
    task automatic stream(int n, int gap_mode, int abort_at, bit noise);
        for (int i = 0; i < n; i++) begin
            int gaps;
            gaps = (i == 0) ? 0 : (gap_mode == 1) ? 1 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
            repeat (gaps) begin
                ifc.in_valid = 1'b0;
                ifc.in_data  = DW'($urandom);
                tick();
            end
            ifc.in_valid = 1'b1;
            ifc.in_data  = tx[i];
            abort = (i == abort_at);
            if (noise) begin
                start = 1'($urandom);
                len   = (AW + 1)'($urandom);
            end
            tick();
            abort = 1'b0;
            start = 1'b0;
        end
        ifc.in_valid = 1'b0;
    endtask

    // Reference: a load of n accepted bytes writes tx[i] at address i in order,
    // byte_cnt = n, checksum = sum of those bytes mod 2^DW.
    task automatic check_load(string tag, int n_exp, int exp_done, logic exp_stall);
        int sum;
        int lim;
        tick(2);
        sum = 0;
        for (int i = 0; i < n_exp; i++) sum += int'(tx[i]);
        chk({tag, "_nwr"}, wq_addr.size(), n_exp);
        lim = (wq_addr.size() < n_exp) ? wq_addr.size() : n_exp;
        for (int i = 0; i < lim; i++) begin
            chk({tag, "_addr"}, wq_addr[i], i);
            chk({tag, "_data"}, wq_data[i], int'(tx[i]));
        end
        chk({tag, "_cnt"}, 32'(byte_cnt), n_exp);
        chk({tag, "_csum"}, 32'(checksum), sum % (1 << DW));
        chk({tag, "_done"}, done_cnt, exp_done);
        chk({tag, "_stall"}, 32'(cpu_stall), 32'(exp_stall));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0;
        ifc.in_valid = 1'b0; ifc.in_data = '0;
        tick(3);
        rst = 1'b0;
        tick();
        chk("rst_ready", 32'(ifc.in_ready), 0);
        chk("rst_we",    32'(ifc.mem_we), 0);
        chk("rst_stall", 32'(cpu_stall), 1);
        chk("rst_done",  32'(done), 0);
        chk("rst_cnt",   32'(byte_cnt), 0);
        chk("rst_csum",  32'(checksum), 0);

        // Four back-to-back bytes
        clr();
        tx[0] = 8'h13; tx[1] = 8'h00; tx[2] = 8'h00; tx[3] = 8'h00;
        do_start(4);
        stream(4, 0, -1, 1'b0);
        check_load("b2b", 4, 1, 1'b0);
        chk("b2b_consec", wq_cyc[3] - wq_cyc[0], 3);
        chk("b2b_donecyc", done_cyc, wq_cyc[3] + 1);

        // abort while in RUN has no effect
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("run_abort_stall", 32'(cpu_stall), 0);

        // in_valid toggling
        clr();
        tx[0] = 8'hA5; tx[1] = 8'h3C; tx[2] = 8'h7E;
        do_start(3);
        stream(3, 1, -1, 1'b0);
        check_load("gap", 3, 1, 1'b0);

        // abort alongside byte 3 of an 8-byte load
        clr();
        for (int i = 0; i < 8; i++) tx[i] = DW'($urandom);
        do_start(8);
        stream(4, 0, 3, 1'b0);
        check_load("abort", 3, 0, 1'b1);
        chk("abort_ready", 32'(ifc.in_ready), 0);

        // zero-length load from IDLE
        clr();
        do_start(0);
        check_load("len0", 0, 1, 1'b0);

        // oversize length saturates to a full memory image; reload from RUN
        clr();
        for (int i = 0; i < 4096; i++) tx[i] = 8'hFF;
        start = 1'b1; len = 13'd5000;
        tick();
        start = 1'b0;
        chk("reload_stall", 32'(cpu_stall), 1);
        chk("reload_ready", 32'(ifc.in_ready), 1);
        stream(4095, 0, -1, 1'b0);
        ifc.in_valid = 1'b1; ifc.in_data = 8'hFF;
        tick();
        ifc.in_valid = 1'b0;
        check_load("full", 4096, 1, 1'b0);
        chk("full_last", wq_addr[4095], 32'hFFF);
        clr();
        ifc.in_valid = 1'b1;
        tick(2);
        ifc.in_valid = 1'b0;
        chk("run_nowr", wq_addr.size(), 0);

        // reset in the middle of a load, then restart
        clr();
        tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33; tx[3] = 8'h44;
        do_start(4);
        stream(2, 0, -1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_ready", 32'(ifc.in_ready), 0);
        chk("mrst_cnt",   32'(byte_cnt), 0);
        chk("mrst_csum",  32'(checksum), 0);
        chk("mrst_stall", 32'(cpu_stall), 1);
        tick(2);
        chk("mrst_done", done_cnt, 0);
        clr();
        do_start(4);
        stream(4, 0, -1, 1'b0);
        check_load("restart", 4, 1, 1'b0);

        // random loads, random gaps, start noise during LOAD
        for (int k = 0; k < 8; k++) begin
            int l;
            clr();
            l = $urandom_range(1, 24);
            for (int i = 0; i < l; i++) tx[i] = DW'($urandom);
            do_start(l);
            stream(l, 2, -1, 1'b1);
            check_load("rand", l, 1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
